// File: rtl/protocol_pkg.sv
// Shared definitions for the single-wire framing protocol: receiver states,
// line levels and the parity convention used by both ends of the link.
package protocol_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic LVL_START   = 1'b1;
  localparam logic LVL_IDLE    = 1'b0;
  localparam logic LVL_STOP    = 1'b0;
  localparam logic PARITY_EVEN = 1'b1;

  // xor_all is the XOR of every data bit and the received parity bit.
  function automatic logic parity_err(input logic xor_all);
    return PARITY_EVEN ? xor_all : ~xor_all;
  endfunction

endpackage

// File: rtl/protocol_sync2.sv
// Two-flop synchronizer bringing the asynchronous serial line into the clk domain.
module protocol_sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Synchronizer chain, cleared to the idle level on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/protocol_rx.sv
// Serial frame receiver: mid-bit sampling of start/data/parity/stop bits and a
// single-entry valid/ready holding register with frame-error and overrun pulses.
module protocol_rx
  import protocol_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              din,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int HALF  = BIT_CYCLES / 2;
  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  rx_state_t         r_state;
  rx_state_t         w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nx;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ferr;
  logic              r_ovr;
  logic              r_err;
  logic              w_din;
  logic              w_half;
  logic              w_bit_end;
  logic              w_last_data;
  logic              w_shift_en;
  logic              w_par_smp;
  logic              w_stop_smp;
  logic              w_good;
  logic              w_bad;
  logic              w_load;
  logic              w_drop;

  protocol_sync2 u_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (din),
    .o_q  (w_din)
  );

  assign w_half      = (r_cnt == CNT_W'(HALF - 1));
  assign w_bit_end   = (r_cnt == CNT_W'(BIT_CYCLES - 1));
  assign w_last_data = (r_idx == IDX_W'(DATA_W - 1));

  // Bits arrive LSB-first, so each new bit enters at the MSB and moves right.
  if (DATA_W > 1) begin : g_shift
    assign w_shift_nx = {w_din, r_shift[DATA_W-1:1]};
  end else begin : g_shift1
    assign w_shift_nx = w_din;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_din == LVL_START) ? START : IDLE;
      START:   w_next = w_half ? ((w_din == LVL_START) ? DATA : IDLE) : START;
      DATA:    w_next = (w_bit_end && w_last_data) ? ((PARITY_EN != 0) ? PARITY : STOP) : DATA;
      PARITY:  w_next = w_bit_end ? STOP : PARITY;
      STOP:    w_next = w_bit_end ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end

  // FSM output decode: sample strobes and holding-register control.
  always_comb begin
    w_shift_en = (r_state == DATA) && w_bit_end;
    w_par_smp  = (r_state == PARITY) && w_bit_end;
    w_stop_smp = (r_state == STOP) && w_bit_end;
    w_good     = w_stop_smp && (w_din == LVL_STOP) && !r_err;
    w_bad      = w_stop_smp && ((w_din != LVL_STOP) || r_err);
    w_load     = w_good && (!r_valid || m_ready);
    w_drop     = w_good && r_valid && !m_ready;
  end

  // Bit timing, shift register, parity flag and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if ((r_state == IDLE) || (w_next != r_state) || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == START) begin
        r_idx <= '0;
        r_err <= 1'b0;
      end else begin
        if (w_shift_en) begin
          r_idx   <= r_idx + IDX_W'(1);
          r_shift <= w_shift_nx;
        end
        if (w_par_smp) begin
          r_err <= parity_err((^r_shift) ^ w_din);
        end
      end
      r_ferr <= w_bad;
      r_ovr  <= w_drop;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_data    = r_data;
  assign m_valid   = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_protocol_rx.sv
// Scoreboard bench for protocol_rx: frames are driven bit-by-bit, expected words
// and error/overrun events are queued with their due cycle and checked on output.
module tb_protocol_rx;
  import protocol_pkg::*;

  localparam int DATA_W     = 8;
  localparam int BIT_CYCLES = 4;
  localparam int PARITY_EN  = 1;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int NBITS      = DATA_W + PARITY_EN + 1;
  localparam int LAT        = 2 + HALF + NBITS * BIT_CYCLES;
  localparam int K_WORD     = 0;
  localparam int K_ERR      = 1;
  localparam int K_OVR      = 2;
  localparam int K_NONE     = 3;

  typedef struct { int data; int cycle; } word_t;
  typedef struct { int kind; int cycle; } ev_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              din = 1'b0;
  logic              m_ready = 1'b1;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              frame_err;
  logic              overrun;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  word_t word_q[$];
  ev_t   ev_q[$];
  word_t w_pop;
  ev_t   e_pop;
  logic  prev_valid = 1'b0;
  logic  prev_hs = 1'b0;
  int    obs_kind;

  protocol_rx #(.DATA_W(DATA_W), .BIT_CYCLES(BIT_CYCLES), .PARITY_EN(PARITY_EN)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .din       (din),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Output monitor: a word counts as new when valid rises or follows a handshake.
  always @(negedge clk) begin
    if (m_valid && (!prev_valid || prev_hs)) begin
      if (word_q.size() == 0) begin
        check("word_extra", int'(m_data), -1);
      end else begin
        w_pop = word_q.pop_front();
        check("word_data", int'(m_data), w_pop.data);
        check("word_cycle", cyc, w_pop.cycle);
      end
    end
    if (frame_err || overrun) begin
      obs_kind = {30'd0, overrun, frame_err};
      if (ev_q.size() == 0) begin
        check("event_extra", obs_kind, 0);
      end else begin
        e_pop = ev_q.pop_front();
        check("event_kind", obs_kind, e_pop.kind);
        check("event_cycle", cyc, e_pop.cycle);
      end
    end
    prev_valid = m_valid;
    prev_hs    = m_valid && m_ready;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Called at posedge+2; the next posedge is the edge that first captures the start bit.
  task automatic send_frame(input logic [DATA_W-1:0] data, input logic par_flip,
                            input logic stop_val, input int nsend, input int kind);
    logic [NBITS:0] bits;
    int t0;
    word_t w;
    ev_t e;
    bits[0]          = 1'b1;
    bits[DATA_W:1]   = data;
    bits[DATA_W+1]   = (^data) ^ par_flip;
    bits[NBITS]      = stop_val;
    t0 = cyc + 1;
    if (kind == K_WORD) begin
      w.data = int'(data);
      w.cycle = t0 + LAT;
      word_q.push_back(w);
    end else if (kind == K_ERR || kind == K_OVR) begin
      e.kind = kind;
      e.cycle = t0 + LAT;
      ev_q.push_back(e);
    end
    for (int i = 0; i < nsend; i++) begin
      din = bits[i];
      idle(BIT_CYCLES);
    end
    din = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t0;
    #1;
    check("rst_m_data", int'(m_data), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b1;
    idle(4);

    // Good frame, consumer always ready: one-cycle valid pulse.
    send_frame(8'hA5, 1'b0, 1'b0, NBITS + 1, K_WORD);
    @(posedge clk);
    @(negedge clk);
    check("t1_valid_hi", int'(m_valid), 1);
    @(negedge clk);
    check("t1_valid_lo", int'(m_valid), 0);
    idle(8);

    send_frame(8'hA5, 1'b1, 1'b0, NBITS + 1, K_ERR);
    idle(8);

    send_frame(8'h3C, 1'b0, 1'b1, NBITS + 1, K_ERR);
    idle(8);
    send_frame(8'h81, 1'b0, 1'b0, NBITS + 1, K_WORD);
    idle(8);

    // Back-to-back frames into a full holding register.
    m_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, NBITS + 1, K_WORD);
    send_frame(8'h22, 1'b0, 1'b0, NBITS + 1, K_OVR);
    @(posedge clk);
    @(negedge clk);
    check("t4_data_kept", int'(m_data), 8'h11);
    check("t4_valid_kept", int'(m_valid), 1);
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_before_hs", int'(m_valid), 1);
    @(negedge clk);
    check("t4_valid_after_hs", int'(m_valid), 0);
    idle(8);

    // One-cycle glitch: false start, back to IDLE by edge 2+HALF.
    t0 = cyc + 1;
    din = 1'b1;
    idle(1);
    din = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_start_seen", int'(dut.r_state), int'(START));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_cycle", cyc, t0 + 2 + HALF);
    check("t5_back_idle", int'(dut.r_state), int'(IDLE));
    idle(8);

    // Reset in the middle of the data bits of 0xFF.
    send_frame(8'hFF, 1'b0, 1'b0, 5, K_NONE);
    rstn = 1'b0;
    #1;
    check("t6_m_data", int'(m_data), 0);
    check("t6_m_valid", int'(m_valid), 0);
    check("t6_frame_err", int'(frame_err), 0);
    check("t6_overrun", int'(overrun), 0);
    check("t6_state", int'(dut.r_state), int'(IDLE));
    idle(2);
    rstn = 1'b1;
    idle(6);
    send_frame(8'h5A, 1'b0, 1'b0, NBITS + 1, K_WORD);
    idle(12);

    check("word_q_empty", word_q.size(), 0);
    check("event_q_empty", ev_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
